// File: rtl/ahbl_pkg.sv
// ahbl_pkg: shared AHB-Lite encodings and the response record used by the
// command master and its response FIFO.
//   HTRANS_*        transfer type encodings (only IDLE and NONSEQ are issued)
//   HSIZE_*         transfer size encodings
//   HBURST_SINGLE   burst encoding for single transfers
//   HPROT_DATA_PRIV protection attributes driven on every transfer
//   ahbl_rsp_t      one response: read data plus error flag
package ahbl_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } ahbl_rsp_t;

endpackage

// File: rtl/ahbl_rsp_fifo.sv
// ahbl_rsp_fifo: synchronous response FIFO with a registered head entry.
// A push into an empty FIFO shows up on valid_o/data_o the following cycle
// (no fall-through). Push and pop may occur in the same cycle.
//   clk, rst     clock, synchronous active-high reset
//   push_i       write push_data_i (caller guarantees the FIFO is not full)
//   push_data_i  response record to store
//   pop_i        consume the head entry (ignored when empty)
//   valid_o      head entry is valid
//   data_o       head entry (registered)
//   count_o      current occupancy, 0..DEPTH
module ahbl_rsp_fifo
  import ahbl_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  ahbl_rsp_t     push_data_i,
  input  logic          pop_i,
  output logic          valid_o,
  output ahbl_rsp_t     data_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ahbl_rsp_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  ahbl_rsp_t     head_q, head_d;
  logic          do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign do_pop = pop_i & (count_q != '0);

  always_comb begin
    count_d  = count_q + CW'(push_i) - CW'(do_pop);
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    head_d   = head_q;
    // When the FIFO is (or becomes) empty, the entry pushed now is the new
    // head; the memory copy is not written yet, so bypass it.
    if (push_i && (count_q == CW'(do_pop))) begin
      head_d = push_data_i;
    end else if (do_pop) begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

  assign valid_o = (count_q != '0);
  assign data_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/ahbl_cmd_master.sv
// ahbl_cmd_master: converts a valid/ready command stream into pipelined
// single AHB-Lite transfers and returns one in-order response per command.
//   HCLK, HRESET                       clock, synchronous active-high reset
//   cmd_valid/ready/addr/write/size/wdata   command stream in
//   rsp_valid/ready/rdata/err          response stream out (buffered)
//   HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HMASTLOCK/HWDATA   bus outputs
//   HREADY/HRESP/HRDATA                bus inputs
// Address phase (A) and data phase (D) registers overlap so back-to-back
// commands run at one per cycle. Commands in A, in D and waiting in the
// response FIFO all count against RSP_DEPTH, which guarantees every
// completing transfer has a FIFO slot.
module ahbl_cmd_master
  import ahbl_pkg::*;
#(
  parameter int RSP_DEPTH = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW:0] CAP = (CW + 1)'(RSP_DEPTH);

  logic        a_vld_q, a_vld_d;
  logic [31:0] a_addr_q, a_addr_d;
  logic        a_write_q, a_write_d;
  logic [2:0]  a_size_q, a_size_d;
  logic [31:0] a_wdata_q, a_wdata_d;

  logic        d_vld_q, d_vld_d;
  logic        d_write_q, d_write_d;
  logic [31:0] d_wdata_q, d_wdata_d;

  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   inflight;
  logic          cmd_acc, a_adv, d_done;
  ahbl_rsp_t     push_rsp, head_rsp;

  assign inflight  = (CW + 1)'(fifo_cnt) + (CW + 1)'(a_vld_q) + (CW + 1)'(d_vld_q);
  assign cmd_ready = (inflight < CAP) & (~a_vld_q | HREADY);
  assign cmd_acc   = cmd_valid & cmd_ready;
  assign a_adv     = a_vld_q & HREADY;
  assign d_done    = d_vld_q & HREADY;

  // Stage A: address phase. Address/control hold their last value when A
  // is empty so the bus does not toggle on idle cycles.
  always_comb begin
    a_vld_d   = a_vld_q;
    a_addr_d  = a_addr_q;
    a_write_d = a_write_q;
    a_size_d  = a_size_q;
    a_wdata_d = a_wdata_q;
    if (cmd_acc) begin
      a_vld_d   = 1'b1;
      a_addr_d  = cmd_addr;
      a_write_d = cmd_write;
      a_size_d  = cmd_size;
      a_wdata_d = cmd_wdata;
    end else if (a_adv) begin
      a_vld_d = 1'b0;
    end
  end

  // Stage D: data phase. HWDATA stays on the bus until HREADY completes it.
  always_comb begin
    d_vld_d   = d_vld_q;
    d_write_d = d_write_q;
    d_wdata_d = d_wdata_q;
    if (a_adv) begin
      d_vld_d   = 1'b1;
      d_write_d = a_write_q;
      d_wdata_d = a_wdata_q;
    end else if (d_done) begin
      d_vld_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_vld_q   <= 1'b0;
      a_addr_q  <= '0;
      a_write_q <= 1'b0;
      a_size_q  <= '0;
      a_wdata_q <= '0;
      d_vld_q   <= 1'b0;
      d_write_q <= 1'b0;
      d_wdata_q <= '0;
    end else begin
      a_vld_q   <= a_vld_d;
      a_addr_q  <= a_addr_d;
      a_write_q <= a_write_d;
      a_size_q  <= a_size_d;
      a_wdata_q <= a_wdata_d;
      d_vld_q   <= d_vld_d;
      d_write_q <= d_write_d;
      d_wdata_q <= d_wdata_d;
    end
  end

  // Response capture: writes report zero data regardless of HRDATA.
  always_comb begin
    push_rsp.rdata = d_write_q ? '0 : HRDATA;
    push_rsp.err   = HRESP;
  end

  ahbl_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (HCLK),
    .rst         (HRESET),
    .push_i      (d_done),
    .push_data_i (push_rsp),
    .pop_i       (rsp_ready),
    .valid_o     (rsp_valid),
    .data_o      (head_rsp),
    .count_o     (fifo_cnt)
  );

  assign rsp_rdata = head_rsp.rdata;
  assign rsp_err   = head_rsp.err;

  assign HTRANS    = a_vld_q ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = a_addr_q;
  assign HWRITE    = a_write_q;
  assign HSIZE     = a_size_q;
  assign HWDATA    = d_wdata_q;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA_PRIV;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahbl_cmd_master.sv
// Bench for ahbl_cmd_master. A small AHB-Lite slave model answers every data
// phase with HRDATA = address + 1, can insert wait states on one address and
// can return a two-cycle ERROR on another. Expected responses are queued when
// a command is accepted and compared in order as the DUT returns them.
// The DUT runs with RSP_DEPTH = 4: A, D and one registered FIFO slot are all
// occupied during streaming, so full one-per-cycle issue needs a cap of 4.
module tb_ahbl_cmd_master;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  exp_t sb[$];

  // slave model configuration and state
  logic [31:0] wait_addr, err_addr;
  int          wait_n;
  logic        err_en;
  logic        sl_vld, sl_write, sl_err;
  logic [31:0] sl_addr;
  int          sl_cnt = 0;
  int          wr_c000_cnt = 0;

  ahbl_cmd_master #(.RSP_DEPTH(DEPTH)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) cyc <= cyc + 1;

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = sl_addr + 32'd1;
    if (sl_vld) begin
      HREADY = (sl_cnt == 0);
      HRESP  = sl_err;
    end
  end

  always @(posedge HCLK) begin
    if (HRESET) begin
      sl_vld   <= 1'b0;
      sl_write <= 1'b0;
      sl_err   <= 1'b0;
      sl_addr  <= '0;
      sl_cnt   <= 0;
    end else if (HREADY) begin
      if (sl_vld && sl_write && sl_addr == 32'hC000) wr_c000_cnt <= wr_c000_cnt + 1;
      sl_vld <= HTRANS[1];
      if (HTRANS[1]) begin
        sl_addr  <= HADDR;
        sl_write <= HWRITE;
        sl_err   <= err_en && (HADDR == err_addr);
        sl_cnt   <= (err_en && HADDR == err_addr) ? 1 : ((HADDR == wait_addr) ? wait_n : 0);
      end
    end else begin
      sl_cnt <= sl_cnt - 1;
    end
  end

  // response scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got rdata=%h err=%b, required no response", rsp_rdata, rsp_err);
        end else begin
          e = sb.pop_front();
          if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
            errors++;
            $display("FAIL rsp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                     rsp_rdata, rsp_err, e.rdata, e.err);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drives one command from posedge+1 until accepted; returns at posedge+1
  // after the accepting edge.
  task automatic send_cmd(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                          input logic [31:0] wdata, input bit expect_rsp);
    bit   ok = 0;
    exp_t e;
    cmd_addr  = addr;
    cmd_write = wr;
    cmd_size  = size;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge HCLK);
      if (cmd_ready === 1'b1) begin
        ok = 1;
        break;
      end
      @(posedge HCLK); #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout: addr=%h not accepted, required acceptance within 60 cycles", addr);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge HCLK); #1;
    last_acc_cyc = cyc;
    if (expect_rsp) begin
      e.rdata = wr ? 32'h0 : addr + 32'd1;
      e.err   = err_en && (addr == err_addr);
      sb.push_back(e);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100; n++) begin
      if (sb.size() == 0) break;
      @(negedge HCLK);
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
    cmd_size = '0; cmd_wdata = '0; rsp_ready = 1'b1;
    wait_addr = 32'hFFFF_FFFF; wait_n = 0; err_addr = 32'hFFFF_FFFF; err_en = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    @(negedge HCLK);
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL reset_htrans: got %b, required 00", HTRANS); end
    checks++; if (HADDR !== 32'h0) begin errors++; $display("FAIL reset_haddr: got %h, required 0", HADDR); end
    checks++; if ({HWRITE, HSIZE} !== 4'b0) begin errors++; $display("FAIL reset_hwrite_hsize: got %b, required 0000", {HWRITE, HSIZE}); end
    checks++; if (HWDATA !== 32'h0) begin errors++; $display("FAIL reset_hwdata: got %h, required 0", HWDATA); end
    checks++; if ({rsp_valid, rsp_rdata, rsp_err} !== 34'h0) begin errors++; $display("FAIL reset_rsp: got valid=%b rdata=%h err=%b, required all 0", rsp_valid, rsp_rdata, rsp_err); end
    checks++; if ({HBURST, HPROT, HMASTLOCK} !== {3'b000, 4'b0011, 1'b0}) begin errors++; $display("FAIL const_outputs: got %b, required 00000110", {HBURST, HPROT, HMASTLOCK}); end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready); end
  endtask

  task automatic test_write();
    exp_t e;
    @(posedge HCLK); #1;
    cmd_addr = 32'h1000; cmd_write = 1'b1; cmd_size = 3'd2; cmd_wdata = 32'hDEADBEEF; cmd_valid = 1'b1;
    @(negedge HCLK);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b, required 1", cmd_ready); end
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
    e.rdata = 32'h0; e.err = 1'b0; sb.push_back(e);
    @(negedge HCLK);
    checks++; if ({HTRANS, HADDR, HWRITE, HSIZE} !== {2'b10, 32'h1000, 1'b1, 3'd2}) begin errors++; $display("FAIL wr_addr_phase: got htrans=%b haddr=%h hwrite=%b hsize=%0d, required 10 00001000 1 2", HTRANS, HADDR, HWRITE, HSIZE); end
    @(negedge HCLK);
    checks++; if (HWDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_hwdata: got %h, required deadbeef", HWDATA); end
    checks++; if ({HTRANS, rsp_valid} !== 3'b000) begin errors++; $display("FAIL wr_t2_idle: got htrans=%b rsp_valid=%b, required 00 0", HTRANS, rsp_valid); end
    @(negedge HCLK);
    checks++; if ({rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 32'h0, 1'b0}) begin errors++; $display("FAIL wr_rsp_t3: got valid=%b rdata=%h err=%b, required 1 0 0", rsp_valid, rsp_rdata, rsp_err); end
    wait_drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL wr_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int run = 0, maxrun = 0, first_acc = 0, span = 0;
    @(posedge HCLK); #1;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          send_cmd(32'(i * 4), 1'b0, 3'd2, 32'h0, 1'b1);
          if (i == 0) first_acc = last_acc_cyc;
        end
        span = last_acc_cyc - first_acc;
      end
      begin
        repeat (12) begin
          @(negedge HCLK);
          if (HTRANS === 2'b10) run++; else run = 0;
          if (run > maxrun) maxrun = run;
        end
      end
    join
    checks++; if (maxrun != 4) begin errors++; $display("FAIL b2b_nonseq_run: got %0d consecutive NONSEQ, required 4", maxrun); end
    checks++; if (span != 3) begin errors++; $display("FAIL b2b_accept_span: got %0d cycles, required 3", span); end
    wait_drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_wait_states();
    int hold_a = 0, hold_d = 0;
    // wait states land while the second write sits in its address phase
    wait_addr = 32'h2000; wait_n = 2;
    @(posedge HCLK); #1;
    fork
      begin
        send_cmd(32'h2000, 1'b1, 3'd2, 32'h1111_1111, 1'b1);
        send_cmd(32'h2004, 1'b1, 3'd2, 32'h2222_2222, 1'b1);
      end
      begin
        repeat (14) begin
          @(negedge HCLK);
          if (HTRANS === 2'b10 && HADDR === 32'h2004) hold_a++;
          if (HWDATA === 32'h1111_1111) hold_d++;
        end
      end
    join
    wait_addr = 32'hFFFF_FFFF; wait_n = 0;
    checks++; if (hold_a != 3) begin errors++; $display("FAIL ws_haddr_hold: got %0d cycles, required 3", hold_a); end
    checks++; if (hold_d != 3) begin errors++; $display("FAIL ws_hwdata_hold: got %0d cycles, required 3", hold_d); end
    wait_drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL ws_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    int acc[5];
    int pop_cyc = 0;
    logic stall_ready = 1'b1;
    rsp_ready = 1'b0;
    @(posedge HCLK); #1;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          send_cmd(32'h100 + 32'(i * 4), 1'b0, 3'd2, 32'h0, 1'b1);
          acc[i] = last_acc_cyc;
        end
      end
      begin
        repeat (8) @(posedge HCLK);
        #1;
        @(negedge HCLK);
        stall_ready = cmd_ready;
        @(posedge HCLK); #1;
        rsp_ready = 1'b1;
        @(posedge HCLK); #1;
        pop_cyc = cyc;
        rsp_ready = 1'b0;
      end
    join
    checks++; if (acc[3] - acc[0] != 3) begin errors++; $display("FAIL bp_first_accepts: got span %0d, required 3", acc[3] - acc[0]); end
    checks++; if (stall_ready !== 1'b0) begin errors++; $display("FAIL bp_cap_ready: got %b, required 0", stall_ready); end
    checks++; if (acc[4] != pop_cyc + 1) begin errors++; $display("FAIL bp_resume: got accept at cycle %0d, required %0d", acc[4], pop_cyc + 1); end
    rsp_ready = 1'b1;
    wait_drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_error();
    int seen0, nonseq_wr = 0;
    err_addr = 32'hBAD0; err_en = 1'b1;
    seen0 = wr_c000_cnt;
    @(posedge HCLK); #1;
    fork
      begin
        send_cmd(32'hBAD0, 1'b0, 3'd2, 32'h0, 1'b1);
        send_cmd(32'hC000, 1'b1, 3'd2, 32'hCAFEF00D, 1'b1);
      end
      begin
        repeat (12) begin
          @(negedge HCLK);
          if (HTRANS === 2'b10 && HADDR === 32'hC000) nonseq_wr++;
        end
      end
    join
    wait_drain();
    checks++; if (nonseq_wr != 2) begin errors++; $display("FAIL err_wr_held: got %0d NONSEQ cycles, required 2", nonseq_wr); end
    checks++; if (wr_c000_cnt - seen0 != 1) begin errors++; $display("FAIL err_wr_issued: got %0d completions, required 1", wr_c000_cnt - seen0); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL err_drain: got %0d pending, required 0", sb.size()); end
    err_en = 1'b0; err_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    // long wait on the first read keeps both A and D occupied at reset
    wait_addr = 32'h3000; wait_n = 3;
    @(posedge HCLK); #1;
    send_cmd(32'h3000, 1'b0, 3'd2, 32'h0, 1'b0);
    send_cmd(32'h3004, 1'b0, 3'd2, 32'h0, 1'b0);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    wait_addr = 32'hFFFF_FFFF; wait_n = 0;
    @(negedge HCLK);
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL rst_mid_htrans: got %b, required 00", HTRANS); end
    checks++; if ({rsp_valid, rsp_rdata} !== 33'h0) begin errors++; $display("FAIL rst_mid_rsp: got valid=%b rdata=%h, required 0 0", rsp_valid, rsp_rdata); end
    repeat (8) begin
      @(negedge HCLK);
      if (rsp_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rst_mid_stale: got %0d valid cycles, required 0", stale); end
    @(posedge HCLK); #1;
    send_cmd(32'h4000, 1'b0, 3'd1, 32'h0, 1'b1);
    wait_drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rst_mid_after: got %0d pending, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_wait_states();
    test_backpressure();
    test_error();
    test_reset_mid();
    repeat (3) @(posedge HCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
